mul_issue_arbiter: RTL and testbench

//  Shares one multi-cycle multiplier execution slot between two issue requesters (RS ports 0/1).

---
 rtl/mul_issue_arbiter.sv | 154 +++++++++++++++
 tb/tb_mul_issue_arbiter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_issue_arbiter.sv
// Two-requester round-robin issue arbiter for one multi-cycle multiplier slot, with speculative kill.
// Optional build macro MUL_EARLY_FINISH_EN: zero-operand products finish in one cycle.
module mul_issue_arbiter #(
  parameter int DATA_LEN    = 32,
  parameter int SPECTAG_LEN = 5,
  parameter int RRF_SEL     = 6,
  parameter int MUL_CYCLES  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [1:0]               req,
  input  logic [2*DATA_LEN-1:0]    src1_i,
  input  logic [2*DATA_LEN-1:0]    src2_i,
  input  logic [1:0]               sgn1_i,
  input  logic [1:0]               sgn2_i,
  input  logic [1:0]               lohi_i,
  input  logic [1:0]               dstval_i,
  input  logic [2*RRF_SEL-1:0]     rrftag_i,
  input  logic [2*SPECTAG_LEN-1:0] spectag_i,
  input  logic [1:0]               specbit_i,
  input  logic                     prmiss,
  input  logic [SPECTAG_LEN-1:0]   spectagfix,
  output logic [1:0]               gnt,
  output logic [DATA_LEN-1:0]      mul_src1,
  output logic [DATA_LEN-1:0]      mul_src2,
  output logic                     mul_sgn1,
  output logic                     mul_sgn2,
  output logic                     mul_lohi,
  input  logic [DATA_LEN-1:0]      mul_result,
  output logic [DATA_LEN-1:0]      result,
  output logic                     rob_we,
  output logic                     rrf_we,
  output logic [RRF_SEL-1:0]       wb_rrftag,
  output logic                     busy
);

  localparam int CNT_W = $clog2(MUL_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MUL_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 last_q, last_d;
  logic [DATA_LEN-1:0]  src1_q, src1_d, src2_q, src2_d;
  logic                 sgn1_q, sgn1_d, sgn2_q, sgn2_d, lohi_q, lohi_d;
  logic                 dstval_q, dstval_d, specbit_q, specbit_d;
  logic [RRF_SEL-1:0]   rrftag_q, rrftag_d;
  logic [SPECTAG_LEN-1:0] spectag_q, spectag_d;

  logic       kill, done, complete, slot_free, sel;
  logic [1:0] elig, gnt_c;

  always_comb begin
    kill = (state_q == RUN) & prmiss & specbit_q & (|(spectag_q & spectagfix));
`ifdef MUL_EARLY_FINISH_EN
    done = (state_q == RUN) & ((cnt_q == CNT_MAX) |
           ((cnt_q == CNT_ONE) & ((src1_q == '0) | (src2_q == '0))));
`else
    done = (state_q == RUN) & (cnt_q == CNT_MAX);
`endif
    complete  = done & ~kill;
    slot_free = (state_q == IDLE) | complete;

    // A request whose own speculative tag is being killed this cycle is not eligible.
    elig[0] = req[0] & ~(prmiss & specbit_i[0] &
                         (|(spectag_i[SPECTAG_LEN-1:0] & spectagfix)));
    elig[1] = req[1] & ~(prmiss & specbit_i[1] &
                         (|(spectag_i[2*SPECTAG_LEN-1:SPECTAG_LEN] & spectagfix)));

    sel   = (elig == 2'b11) ? ~last_q : elig[1];
    gnt_c = 2'b00;
    if (slot_free && (|elig) && !reset)
      gnt_c = sel ? 2'b10 : 2'b01;

    state_d   = state_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    src1_d    = src1_q;
    src2_d    = src2_q;
    sgn1_d    = sgn1_q;
    sgn2_d    = sgn2_q;
    lohi_d    = lohi_q;
    dstval_d  = dstval_q;
    rrftag_d  = rrftag_q;
    spectag_d = spectag_q;
    specbit_d = specbit_q;

    if (|gnt_c) begin
      state_d   = RUN;
      cnt_d     = CNT_ONE;
      last_d    = sel;
      src1_d    = sel ? src1_i[2*DATA_LEN-1:DATA_LEN] : src1_i[DATA_LEN-1:0];
      src2_d    = sel ? src2_i[2*DATA_LEN-1:DATA_LEN] : src2_i[DATA_LEN-1:0];
      sgn1_d    = sel ? sgn1_i[1] : sgn1_i[0];
      sgn2_d    = sel ? sgn2_i[1] : sgn2_i[0];
      lohi_d    = sel ? lohi_i[1] : lohi_i[0];
      dstval_d  = sel ? dstval_i[1] : dstval_i[0];
      rrftag_d  = sel ? rrftag_i[2*RRF_SEL-1:RRF_SEL] : rrftag_i[RRF_SEL-1:0];
      spectag_d = sel ? spectag_i[2*SPECTAG_LEN-1:SPECTAG_LEN]
                      : spectag_i[SPECTAG_LEN-1:0];
      specbit_d = sel ? specbit_i[1] : specbit_i[0];
    end else if (kill || complete) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (state_q == RUN) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      last_q    <= 1'b1;
      src1_q    <= '0;
      src2_q    <= '0;
      sgn1_q    <= 1'b0;
      sgn2_q    <= 1'b0;
      lohi_q    <= 1'b0;
      dstval_q  <= 1'b0;
      rrftag_q  <= '0;
      spectag_q <= '0;
      specbit_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      src1_q    <= src1_d;
      src2_q    <= src2_d;
      sgn1_q    <= sgn1_d;
      sgn2_q    <= sgn2_d;
      lohi_q    <= lohi_d;
      dstval_q  <= dstval_d;
      rrftag_q  <= rrftag_d;
      spectag_q <= spectag_d;
      specbit_q <= specbit_d;
    end
  end

  assign gnt       = gnt_c;
  assign mul_src1  = src1_q;
  assign mul_src2  = src2_q;
  assign mul_sgn1  = sgn1_q;
  assign mul_sgn2  = sgn2_q;
  assign mul_lohi  = lohi_q;
  assign result    = mul_result;
  assign rob_we    = complete;
  assign rrf_we    = complete & dstval_q;
  assign wb_rrftag = rrftag_q;
  assign busy      = (state_q == RUN);

endmodule

// File: tb/tb_mul_issue_arbiter.sv
// Scoreboard bench for mul_issue_arbiter: directed issues push expected completions, a monitor checks them.
module tb_mul_issue_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req;
  logic [63:0] src1_i, src2_i;
  logic [1:0]  sgn1_i, sgn2_i, lohi_i, dstval_i, specbit_i;
  logic [11:0] rrftag_i;
  logic [9:0]  spectag_i;
  logic        prmiss;
  logic [4:0]  spectagfix;
  logic [1:0]  gnt;
  logic [31:0] mul_src1, mul_src2, mul_result, result;
  logic        mul_sgn1, mul_sgn2, mul_lohi, rob_we, rrf_we, busy;
  logic [5:0]  wb_rrftag;

  mul_issue_arbiter dut (
    .clk(clk), .reset(reset), .req(req), .src1_i(src1_i), .src2_i(src2_i),
    .sgn1_i(sgn1_i), .sgn2_i(sgn2_i), .lohi_i(lohi_i), .dstval_i(dstval_i),
    .rrftag_i(rrftag_i), .spectag_i(spectag_i), .specbit_i(specbit_i),
    .prmiss(prmiss), .spectagfix(spectagfix), .gnt(gnt),
    .mul_src1(mul_src1), .mul_src2(mul_src2), .mul_sgn1(mul_sgn1), .mul_sgn2(mul_sgn2),
    .mul_lohi(mul_lohi), .mul_result(mul_result), .result(result), .rob_we(rob_we),
    .rrf_we(rrf_we), .wb_rrftag(wb_rrftag), .busy(busy)
  );

  always #5 clk = ~clk;

  // Combinational multiplier datapath behind the slot.
  logic signed [32:0] ma, mb;
  logic signed [65:0] mp;
  always_comb begin
    ma = {mul_sgn1 & mul_src1[31], mul_src1};
    mb = {mul_sgn2 & mul_src2[31], mul_src2};
    mp = 66'(ma) * 66'(mb);
    mul_result = mul_lohi ? mp[63:32] : mp[31:0];
  end

  typedef struct {
    logic [31:0] res;
    logic        rrf;
    logic [5:0]  tag;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  int tests = 0;
  int fails = 0;
  int cyc = 0;

`ifdef MUL_EARLY_FINISH_EN
  localparam int ZERO_LAT = 1;
`else
  localparam int ZERO_LAT = 4;
`endif

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rob_we === 1'b1) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_rob_we: got rob_we=1 expected 0 (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", result, e.res);
        chk("rrf_we", rrf_we, e.rrf);
        chk("wb_rrftag", wb_rrftag, e.tag);
        chk("complete_cycle", cyc, e.cyc);
      end
    end else if (rrf_we !== 1'b0) begin
      tests++;
      fails++;
      $display("FAIL rrf_without_rob: got rrf_we=%b expected 0 (cycle %0d)", rrf_we, cyc);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rs(input int i, input logic [31:0] a, input logic [31:0] b,
                        input logic s1, input logic s2, input logic lh, input logic dv,
                        input logic [5:0] tag, input logic [4:0] st, input logic sp);
    src1_i[i*32 +: 32]   = a;
    src2_i[i*32 +: 32]   = b;
    sgn1_i[i]            = s1;
    sgn2_i[i]            = s2;
    lohi_i[i]            = lh;
    dstval_i[i]          = dv;
    rrftag_i[i*6 +: 6]   = tag;
    spectag_i[i*5 +: 5]  = st;
    specbit_i[i]         = sp;
  endtask

  task automatic push(input logic [31:0] r, input logic rf, input logic [5:0] t, input int c);
    exp_t e;
    e.res = r; e.rrf = rf; e.tag = t; e.cyc = c;
    sb.push_back(e);
  endtask

  task automatic drain();
    for (int k = 0; k < 30 && (sb.size() != 0 || busy); k++) step();
    chk("drain_queue", sb.size(), 0);
    chk("drain_busy", busy, 0);
  endtask

  task automatic single(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input logic lh, input logic dv, input logic [5:0] tag,
                        input logic [31:0] exp_res, input int lat);
    set_rs(0, a, b, s, s, lh, dv, tag, 5'b0, 1'b0);
    req = 2'b01;
    #1;
    chk("single_gnt", gnt, 2'b01);
    push(exp_res, dv, tag, cyc + lat);
    step();
    req = 2'b00;
    drain();
  endtask

  logic [1:0] gseq [5];

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; prmiss = 1'b0; spectagfix = '0;
    src1_i = '0; src2_i = '0; sgn1_i = '0; sgn2_i = '0; lohi_i = '0;
    dstval_i = '0; rrftag_i = '0; spectag_i = '0; specbit_i = '0;
    set_rs(0, 32'd3, 32'd5, 1'b0, 1'b0, 1'b0, 1'b1, 6'h15, 5'b0, 1'b0);
    req = 2'b01;
    step(); step();
    chk("rst_gnt", gnt, 2'b00);
    chk("rst_busy", busy, 0);
    chk("rst_rob_we", rob_we, 0);
    chk("rst_src1", mul_src1, 0);
    reset = 1'b0;

    // 3*5 from requester 0
    #1;
    chk("t1_gnt", gnt, 2'b01);
    push(32'd15, 1'b1, 6'h15, cyc + 4);
    step();
    req = 2'b00;
    chk("t1_busy", busy, 1);
    chk("t1_src1", mul_src1, 32'd3);
    drain();

    // Both requesting continuously: last grant was 0, so 1 first, then 0 back-to-back
    set_rs(0, 32'd2, 32'd4, 1'b0, 1'b0, 1'b0, 1'b1, 6'd1, 5'b0, 1'b0);
    set_rs(1, 32'd6, 32'd7, 1'b0, 1'b0, 1'b0, 1'b1, 6'd2, 5'b0, 1'b0);
    req = 2'b11;
    gseq[0] = 2'b10; gseq[1] = 2'b00; gseq[2] = 2'b00; gseq[3] = 2'b00; gseq[4] = 2'b01;
    push(32'd42, 1'b1, 6'd2, cyc + 4);
    push(32'd8, 1'b1, 6'd1, cyc + 8);
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("b2b_gnt%0d", k), gnt, gseq[k]);
      if (k > 0) chk($sformatf("b2b_busy%0d", k), busy, 1);
      step();
    end
    req = 2'b00;
    chk("b2b_nobubble", busy, 1);
    drain();

    // High half, signed and unsigned, dstval 0 and 1
    single(32'hFFFF_FFFE, 32'd3, 1'b1, 1'b1, 1'b0, 6'h3F, 32'hFFFF_FFFF, 4);
    single(32'hFFFF_FFFE, 32'd3, 1'b0, 1'b1, 1'b1, 6'h2A, 32'h0000_0002, 4);
    single(32'hFFFF_FFFE, 32'd3, 1'b1, 1'b0, 1'b1, 6'h2B, 32'hFFFF_FFFA, 4);

    // Grant suppression for a killed speculative requester in IDLE
    set_rs(0, 32'd9, 32'd9, 1'b0, 1'b0, 1'b0, 1'b1, 6'h06, 5'b00100, 1'b1);
    set_rs(1, 32'd5, 32'd5, 1'b0, 1'b0, 1'b0, 1'b1, 6'h07, 5'b00000, 1'b0);
    prmiss = 1'b1; spectagfix = 5'b00100;
    req = 2'b01;
    #1;
    chk("supp_only0", gnt, 2'b00);
    req = 2'b11;
    #1;
    chk("supp_pick1", gnt, 2'b10);
    push(32'd25, 1'b1, 6'h07, cyc + 4);
    step();
    prmiss = 1'b0; req = 2'b00;
    drain();

    // Kill mid-run: non-matching fix first, then matching fix with a waiting requester
    set_rs(0, 32'd4, 32'd4, 1'b0, 1'b0, 1'b0, 1'b1, 6'h11, 5'b00100, 1'b1);
    req = 2'b01;
    #1;
    chk("kill_gnt", gnt, 2'b01);
    step();
    req = 2'b00; prmiss = 1'b1; spectagfix = 5'b00010;
    step();
    chk("kill_nomatch_busy", busy, 1);
    spectagfix = 5'b00100; req = 2'b10;
    #1;
    chk("kill_nogrant", gnt, 2'b00);
    chk("kill_rob_we", rob_we, 0);
    step();
    prmiss = 1'b0; req = 2'b00;
    chk("kill_idle", busy, 0);
    for (int k = 0; k < 6; k++) step();

    // Non-matching mispredict late in the run has no effect
    set_rs(0, 32'd10, 32'd10, 1'b0, 1'b0, 1'b0, 1'b1, 6'h12, 5'b00010, 1'b1);
    req = 2'b01;
    push(32'd100, 1'b1, 6'h12, cyc + 4);
    step();
    req = 2'b00;
    step(); step();
    prmiss = 1'b1; spectagfix = 5'b01000;
    #1;
    chk("nomatch_busy", busy, 1);
    step();
    prmiss = 1'b0;
    drain();

    // Kill landing on the completion cycle
    set_rs(0, 32'd6, 32'd6, 1'b0, 1'b0, 1'b0, 1'b1, 6'h13, 5'b00100, 1'b1);
    req = 2'b01;
    step();
    req = 2'b00;
    step(); step(); step();
    prmiss = 1'b1; spectagfix = 5'b00100; req = 2'b10;
    #1;
    chk("kc_busy", busy, 1);
    chk("kc_rob_we", rob_we, 0);
    chk("kc_rrf_we", rrf_we, 0);
    chk("kc_gnt", gnt, 2'b00);
    step();
    prmiss = 1'b0; req = 2'b00;
    chk("kc_idle", busy, 0);
    for (int k = 0; k < 6; k++) step();

    // Zero operand latency depends on the build
    single(32'd0, 32'd7, 1'b0, 1'b0, 1'b1, 6'h14, 32'd0, ZERO_LAT);

    // Reset asserted mid-run
    set_rs(0, 32'd5, 32'd5, 1'b0, 1'b0, 1'b0, 1'b1, 6'h15, 5'b0, 1'b0);
    req = 2'b01;
    #1;
    chk("mr_gnt", gnt, 2'b01);
    step();
    req = 2'b00;
    step();
    req = 2'b11;
    chk("mr_busy_pre", busy, 1);
    reset = 1'b1;
    #1;
    chk("mr_busy", busy, 0);
    chk("mr_gnt_rst", gnt, 2'b00);
    chk("mr_src1", mul_src1, 0);
    step(); step();
    reset = 1'b0; req = 2'b00;
    for (int k = 0; k < 8; k++) step();
    chk("mr_idle", busy, 0);
    chk("final_queue", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
